// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST controller: FSM state encoding and run-mode codes.
// Mode 2'b11 is not listed here because the controller treats it as a write+read run.
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] MODE_WR_RD = 2'b00;
   localparam logic [1:0] MODE_WR    = 2'b01;
   localparam logic [1:0] MODE_RD    = 2'b10;

endpackage

// File: rtl/mem_bist_pattern.sv
// Word index counter plus running pattern accumulator (SEED + idx*STEP built by repeated add).
// The *_nxt outputs let the owner register the following word one cycle ahead.
module mem_bist_pattern #(
   parameter int          DATA_W = 32,
   parameter int          ADDR_W = 32,
   parameter logic [31:0] SEED   = 32'h0000_0004,
   parameter logic [31:0] STEP   = 32'h0000_0005
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] idx,
   output logic [ADDR_W-1:0] idx_nxt,
   output logic [DATA_W-1:0] pat,
   output logic [DATA_W-1:0] pat_nxt
);

   localparam logic [DATA_W-1:0] SEED_T = DATA_W'(SEED);
   localparam logic [DATA_W-1:0] STEP_T = DATA_W'(STEP);

   assign idx_nxt = idx + ADDR_W'(1);
   assign pat_nxt = pat + STEP_T;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         pat <= SEED_T;
      end else if (clear) begin
         idx <= '0;
         pat <= SEED_T;
      end else if (advance) begin
         idx <= idx_nxt;
         pat <= pat_nxt;
      end
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes an arithmetic pattern over a window, reads it back, compares.
// All memory-side outputs are registered; read data is compared one cycle after its address.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter int          ADDR_W = 32,
   parameter int          ERR_W  = 16,
   parameter logic [31:0] SEED   = 32'h0000_0004,
   parameter logic [31:0] STEP   = 32'h0000_0005
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [DATA_W-1:0] SEED_T = DATA_W'(SEED);

   state_t            state;
   logic [1:0]        mode_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] eaddr_q;
   logic [DATA_W-1:0] exp_q;
   logic              cmp_vld;

   logic              pat_clear;
   logic              pat_adv;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] pat_nxt;
   logic              last;
   logic              mismatch;

   assign last     = (idx == len_r - ADDR_W'(1));
   assign mismatch = cmp_vld && (mem_rdata != exp_q);

   // The same generator restarts at the window start for the read pass.
   always_comb begin
      pat_clear = 1'b0;
      pat_adv   = 1'b0;
      if (state == IDLE && start)
         pat_clear = 1'b1;
      else if (state == WRITE && last)
         pat_clear = 1'b1;
      else if ((state == WRITE || state == READ) && !last)
         pat_adv = 1'b1;
   end

   mem_bist_pattern #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .SEED   (SEED),
      .STEP   (STEP)
   ) u_pattern (
      .clk     (clk),
      .rst     (rst),
      .clear   (pat_clear),
      .advance (pat_adv),
      .idx     (idx),
      .idx_nxt (idx_nxt),
      .pat     (pat),
      .pat_nxt (pat_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         mode_r         <= '0;
         base_r         <= '0;
         len_r          <= '0;
         eaddr_q        <= '0;
         exp_q          <= '0;
         cmp_vld        <= 1'b0;
         mem_wr_en      <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         done    <= 1'b0;
         cmp_vld <= 1'b0;

         // pass still high means no earlier mismatch in this run
         if (mismatch) begin
            if (err_count != '1)
               err_count <= err_count + ERR_W'(1);
            if (pass)
               first_err_addr <= eaddr_q;
            pass <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  mode_r         <= mode;
                  base_r         <= base_addr;
                  len_r          <= length;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  pass           <= 1'b1;
                  if (length == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     busy     <= 1'b1;
                     mem_addr <= base_addr;
                     if (mode == MODE_RD) begin
                        state <= READ;
                     end else begin
                        state     <= WRITE;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= SEED_T;
                     end
                  end
               end
            end
            WRITE: begin
               if (last) begin
                  mem_wr_en <= 1'b0;
                  if (mode_r == MODE_WR) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= READ;
                     mem_addr <= base_r;
                  end
               end else begin
                  mem_addr  <= base_r + idx_nxt;
                  mem_wdata <= pat_nxt;
               end
            end
            READ: begin
               cmp_vld <= 1'b1;
               exp_q   <= pat;
               eaddr_q <= mem_addr;
               if (last)
                  state <= DRAIN;
               else
                  mem_addr <= base_r + idx_nxt;
            end
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural RAM with read-fault injection, plus a window-level
// reference model that predicts per-cycle memory traffic and the final verdict of each run.
module tb_mem_bist_ctrl;

   localparam int          DW      = 32;
   localparam int          AW      = 8;
   localparam int          EW      = 3;
   localparam int          ERR_MAX = 7;
   localparam logic [31:0] SEED    = 32'h0000_0004;
   localparam logic [31:0] STEP    = 32'h0000_0005;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          start     = 1'b0;
   logic [1:0]    mode      = 2'b00;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] length    = '0;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_err_addr;

   bit [31:0] ram     [256];
   bit [31:0] ref_mem [256];
   bit        fault   [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bist_ctrl #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .ERR_W  (EW),
      .SEED   (SEED),
      .STEP   (STEP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .base_addr      (base_addr),
      .length         (length),
      .mem_wr_en      (mem_wr_en),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   // Single-port RAM, one-cycle read latency; faulty words read back as zero.
   always @(posedge clk) begin
      if (mem_wr_en)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= fault[mem_addr] ? 32'd0 : ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int k = 0; k < 256; k++) fault[k] = 1'b0;
   endtask

   // One complete run: predict from the window rules, drive start, follow every cycle to done.
   task automatic run(input logic [1:0] md, input int b, input int l, input bit hold);
      int          exp_done;
      int          rd_first;
      int          c;
      int          errs;
      int          first;
      int          a;
      bit          do_wr;
      bit          do_rd;
      logic [31:0] v;

      do_wr = (md != 2'b10) && (l > 0);
      do_rd = (md != 2'b01) && (l > 0);
      if (l == 0)            exp_done = 1;
      else if (md == 2'b01)  exp_done = l + 1;
      else if (md == 2'b10)  exp_done = l + 2;
      else                   exp_done = 2 * l + 2;
      rd_first = (md == 2'b10) ? 1 : l + 1;

      errs  = 0;
      first = 0;
      if (do_wr)
         for (int i = 0; i < l; i++) ref_mem[(b + i) % 256] = SEED + STEP * i;
      if (do_rd)
         for (int i = 0; i < l; i++) begin
            a = (b + i) % 256;
            v = fault[a] ? 32'd0 : ref_mem[a];
            if (v != SEED + STEP * i) begin
               if (errs == 0) first = a;
               if (errs < ERR_MAX) errs++;
            end
         end

      @(posedge clk); #1;
      start     = 1'b1;
      mode      = md;
      base_addr = AW'(b);
      length    = AW'(l);
      @(posedge clk); #1;
      if (!hold) start = 1'b0;

      c = 1;
      forever begin
         chk("busy", 32'(busy), 32'(c < exp_done));
         if (do_wr && c <= l) begin
            chk("wr_en", 32'(mem_wr_en), 32'd1);
            chk("wr_addr", 32'(mem_addr), (b + c - 1) % 256);
            chk("wr_data", mem_wdata, SEED + STEP * (c - 1));
         end else begin
            chk("wr_en_low", 32'(mem_wr_en), 32'd0);
         end
         if (do_rd && c >= rd_first && c < rd_first + l)
            chk("rd_addr", 32'(mem_addr), (b + c - rd_first) % 256);
         if (done || c >= exp_done + 4) break;
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;

      chk("done_cycle", c, exp_done);
      chk("pass", 32'(pass), 32'(errs == 0));
      chk("err_count", 32'(err_count), errs);
      chk("first_err_addr", 32'(first_err_addr), first);
      @(posedge clk); #1;
      chk("after_busy", 32'(busy), 32'd0);
      chk("after_done", 32'(done), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_errs"}, 32'(err_count), 32'd0);
      chk({tag, "_first"}, 32'(first_err_addr), 32'd0);
   endtask

   initial begin
      int b;
      int l;
      int md;

      clear_faults();
      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic write+read at base 4: pattern 4, 9, 14, 19; done in cycle 10.
      run(2'b00, 4, 4, 1'b0);

      fault[6] = 1'b1;
      run(2'b00, 4, 4, 1'b0);
      fault[5] = 1'b1;
      run(2'b00, 4, 4, 1'b0);
      clear_faults();

      // Address window wraps 254, 255, 0, 1.
      run(2'b00, 254, 4, 1'b0);

      run(2'b00, 10, 0, 1'b0);
      run(2'b00, 20, 4, 1'b1);
      run(2'b01, 30, 3, 1'b0);
      run(2'b10, 30, 3, 1'b0);
      run(2'b11, 50, 2, 1'b0);
      run(2'b10, 60, 1, 1'b0);

      // Ten faulty words saturate the 3-bit error counter.
      for (int k = 100; k < 110; k++) fault[k] = 1'b1;
      run(2'b00, 100, 10, 1'b0);
      clear_faults();

      // Reset during the second write word: only word 0 reaches memory.
      @(posedge clk); #1;
      start     = 1'b1;
      mode      = 2'b00;
      base_addr = AW'(40);
      length    = AW'(4);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;
      ref_mem[40] = SEED;
      run(2'b10, 40, 4, 1'b0);

      for (int n = 0; n < 10; n++) begin
         md = int'($urandom_range(0, 3));
         b  = int'($urandom_range(0, 255));
         l  = int'($urandom_range(0, 12));
         clear_faults();
         if (l > 0 && $urandom_range(0, 1) == 1)
            fault[(b + int'($urandom_range(0, l - 1))) % 256] = 1'b1;
         run(2'(md), b, l, n[0]);
      end
      clear_faults();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
